dp_ram_sync: RTL and testbench
==============================

// Module: dp_ram_sync
// PURPOSE
//  Multi-channel simple dual-port RAM with a registered read, a rd_valid strobe and a
//  write-to-read bypass. A clear engine zeroes the whole array after reset or on request.
//  Holds per-voice state (phase accumulators, envelope levels, filter taps) for the synth
//  voice engines. The channel index selects a bank; each bank is RAM_DEPTH words deep.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits
//  ADDR_WIDTH  6   address width within one channel
//  CH_WIDTH    2   channel index width; NUM_CH = 1<<CH_WIDTH
//  RAM_DEPTH   1<<ADDR_WIDTH  words per channel; total words = NUM_CH*RAM_DEPTH
// PORTS
//  clk      in   1           system clock, all logic on posedge
//  reset_n  in   1           asynchronous, active-low reset
//  clr      in   1           1-cycle pulse: restart the zero-fill sweep
//  ready    out  1           1 = RAM accepts wr/rd; 0 while clearing
//  wr       in   1           write strobe
//  wr_ch    in   CH_WIDTH    write channel
//  wr_addr  in   ADDR_WIDTH  write address
//  wr_data  in   DATA_WIDTH  write data
//  rd       in   1           read strobe
//  rd_ch    in   CH_WIDTH    read channel
//  rd_addr  in   ADDR_WIDTH  read address
//  rd_data  out  DATA_WIDTH  read data, held until the next accepted read
//  rd_valid out  1           1-cycle pulse: rd_data carries the requested word
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (reset_n).
//  - Reset values: ready=0, rd_valid=0, rd_data=0, state=CLEAR, clear counter=0.
//  - Array contents are not touched by reset_n itself; the CLEAR sweep zeroes them.
//  - Flat address = {ch, addr}, CH_WIDTH+ADDR_WIDTH bits. Clear counter has the same width.
//  - FSM states CLEAR and RUN:
//    - CLEAR: each posedge writes 0 to word[cnt], then cnt++.
//    - On the edge that writes word[NUM_CH*RAM_DEPTH-1], go to RUN; ready=1 after that edge.
//    - A full sweep takes exactly NUM_CH*RAM_DEPTH cycles.
//    - RUN: clr=1 -> CLEAR, cnt=0, ready=0 on the next edge.
//    - clr during CLEAR restarts the sweep at cnt=0.
//  - While ready=0, wr and rd are ignored: no array write, and rd_valid stays 0.
//  - Write: ready & wr -> word[{wr_ch,wr_addr}] <= wr_data on the same edge.
//  - Read latency 1: ready & rd sampled at edge N -> rd_data valid and rd_valid=1 after edge N.
//  - rd_data holds its value when no read is accepted.
//  - Same-cycle collision: if rd & wr hit the same {ch,addr}, rd_data = new wr_data
//    (write-first bypass). Different addresses are independent.
//  - Back-to-back reads: one read per cycle at full throughput, rd_valid high continuously.
//  - A read accepted on the edge where clr is sampled in RUN still completes;
//    clr takes effect from the next cycle.
//  - reset_n asserted mid-sweep or mid-read: immediate return to reset values.
//    An in-flight rd_valid is lost.
// CONFIGURATION
//  - DP_RAM_SYNC_OUT_REG_EN defined: adds an output register stage.
//    - Read latency becomes 2; rd_valid is delayed with the data.
//    - The bypass still returns the write-first value.
//    - Reset clears both stages.
//  - Undefined: latency 1 as described above.
// STRUCTURE
//  - dp_ram_pkg: FSM state encodings ST_CLEAR/ST_RUN and a function for the
//    flat-address width (CH_WIDTH+ADDR_WIDTH).
//  - Sub-module dp_ram_core: bare sync-read storage array (one write port, one registered
//    read port, no reset), so the tools infer block RAM.
//  - dp_ram_sync owns the FSM, clear counter, write mux (clear vs user), bypass compare,
//    valid pipeline and the optional output stage.
// TESTING  (DATA_WIDTH=16, ADDR_WIDTH=3, CH_WIDTH=1 -> 16 words)
//  1. Release reset_n, rd held high -> ready=0 and rd_valid=0 for 16 cycles;
//     ready=1 after the 16th edge.
//  2. After ready: wr ch1/a5 = 16'hBEEF, then rd ch1/a5 -> next cycle rd_data=BEEF,
//     rd_valid=1 for 1 cycle. rd ch0/a5 returns 0.
//  3. Same cycle: wr ch0/a2 = 16'h1234 and rd ch0/a2 (prior value 0)
//     -> rd_data=1234 next cycle.
//  4. Fill all 16 words with their index; pulse clr; read all 16 after ready returns
//     -> all read back 0. ready was low exactly 16 cycles.
//  5. Assert reset_n low at cycle 7 of a sweep -> outputs go to reset values immediately;
//     a full 16-cycle sweep follows release. wr/rd issued while ready=0 have no effect.
//  6. With DP_RAM_SYNC_OUT_REG_EN: repeat tests 2-3 -> data and rd_valid appear 2 cycles
//     after rd. Back-to-back reads of a0..a7 -> rd_valid high for 8 consecutive cycles.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared definitions for the multi-channel dual-port voice-state RAM:
// controller state encoding and the flat {channel, address} width helper.
package dp_ram_pkg;

    // Controller states: zero-fill sweep in progress, or normal access
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Width of the flat word index {ch, addr} across all channel banks
    function automatic int flat_addr_width(input int ch_width, input int addr_width);
        return ch_width + addr_width;
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// Bare storage array: one write port and one registered read port.
// No reset and no bypass logic, so synthesis can map it onto block RAM.
module dp_ram_core
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FLAT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [FLAT_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [FLAT_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_q
);

    localparam int WORDS = 1 << FLAT_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its last word while no read is enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dp_ram_sync.sv
// Multi-channel simple dual-port RAM with registered read, rd_valid strobe,
// write-first bypass on same-word collisions and a zero-fill clear engine
// that sweeps the whole array after reset or on a clr pulse.
// Optional build macro DP_RAM_SYNC_OUT_REG_EN adds an output register stage
// (read latency 2 instead of 1, rd_valid delayed with the data).
module dp_ram_sync
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int CH_WIDTH   = 2,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    output logic                  ready,
    input  logic                  wr,
    input  logic [CH_WIDTH-1:0]   wr_ch,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    input  logic [CH_WIDTH-1:0]   rd_ch,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int FLAT_WIDTH = flat_addr_width(CH_WIDTH, ADDR_WIDTH);
    localparam logic [FLAT_WIDTH-1:0] LAST_WORD =
        FLAT_WIDTH'((1 << CH_WIDTH) * RAM_DEPTH - 1);

    state_t                state;
    logic [FLAT_WIDTH-1:0] cnt;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [FLAT_WIDTH-1:0] wr_flat;
    logic [FLAT_WIDTH-1:0] rd_flat;

    logic                  mem_we;
    logic [FLAT_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] core_q;

    logic                  vld_p0;
    logic                  byp_p0;
    logic [DATA_WIDTH-1:0] byp_data_p0;
    logic [DATA_WIDTH-1:0] data_p0;

    assign wr_flat = {wr_ch, wr_addr};
    assign rd_flat = {rd_ch, rd_addr};

    // User accesses are only honoured once the sweep has finished
    assign wr_acc = ready & wr;
    assign rd_acc = ready & rd;

    // Controller: zero-fill sweep, then normal operation until clr restarts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST_WORD) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + FLAT_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ready <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Write mux: the sweep owns the write port while clearing
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_flat;
        mem_wdata = wr_data;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    dp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .FLAT_WIDTH (FLAT_WIDTH)
    ) u_core (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_waddr),
        .wr_data (mem_wdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_flat),
        .rd_q    (core_q)
    );

    // Stage p0: read valid plus write-first bypass capture. The bypass flag
    // resets to 1 with zero data so rd_data reads 0 before the first read,
    // since the array output register itself has no reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0      <= 1'b0;
            byp_p0      <= 1'b1;
            byp_data_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                byp_p0      <= wr_acc && (wr_flat == rd_flat);
                byp_data_p0 <= wr_data;
            end
        end
    end

    assign data_p0 = byp_p0 ? byp_data_p0 : core_q;

`ifdef DP_RAM_SYNC_OUT_REG_EN
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Stage p1: optional output register, data held between accepted reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= data_p0;
            end
        end
    end

    assign rd_data  = data_p1;
    assign rd_valid = vld_p1;
`else
    assign rd_data  = data_p0;
    assign rd_valid = vld_p0;
`endif

endmodule

// File: tb/tb_dp_ram_sync.sv
// Self-checking bench for dp_ram_sync (16-word configuration: 2 channels x 8).
// A word-array model with a sweep countdown predicts ready/rd_valid/rd_data
// every cycle; directed literal checks pin the model's key results.
module tb_dp_ram_sync;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int CW    = 1;
    localparam int WORDS = 16;
`ifdef DP_RAM_SYNC_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clr = 1'b0;
    logic          ready;
    logic          wr = 1'b0;
    logic [CW-1:0] wr_ch = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd = 1'b0;
    logic [CW-1:0] rd_ch = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_ram_sync #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CH_WIDTH   (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .ready    (ready),
        .wr       (wr),
        .wr_ch    (wr_ch),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd       (rd),
        .rd_ch    (rd_ch),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    // Behavioural model
    logic [DW-1:0] m_mem [WORDS];
    logic          m_ready;
    int            m_clear_left;
    logic          m_s1_v;
    logic [DW-1:0] m_s1_d;
    logic          m_valid;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_ready      = 1'b0;
        m_clear_left = WORDS;
        m_s1_v       = 1'b0;
        m_s1_d       = '0;
        m_valid      = 1'b0;
        m_data       = '0;
    endtask

    task automatic model_edge();
        logic          nv;
        logic [DW-1:0] nd;
        nv = 1'b0;
        nd = '0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_ready) begin
            if (wr) m_mem[{wr_ch, wr_addr}] = wr_data;
            if (rd) begin
                nv = 1'b1;
                nd = m_mem[{rd_ch, rd_addr}];
            end
            if (clr) begin
                m_ready      = 1'b0;
                m_clear_left = WORDS;
            end
        end else if (clr) begin
            m_clear_left = WORDS;
        end else begin
            m_clear_left = m_clear_left - 1;
            if (m_clear_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
            end
        end
        if (LAT == 1) begin
            m_valid = nv;
            if (nv) m_data = nd;
        end else begin
            m_valid = m_s1_v;
            if (m_s1_v) m_data = m_s1_d;
            m_s1_v = nv;
            m_s1_d = nd;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("cyc_ready", 32'(ready), 32'(m_ready));
        check("cyc_rd_valid", 32'(rd_valid), 32'(m_valid));
        check("cyc_rd_data", 32'(rd_data), 32'(m_data));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            n++;
            step();
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic write(input int ch, input int a, input logic [DW-1:0] d);
        wr = 1'b1; wr_ch = CW'(ch); wr_addr = AW'(a); wr_data = d;
        step();
        wr = 1'b0;
    endtask

    // Called just after the edge that sampled the read request
    task automatic finish_read(input string name, input logic [DW-1:0] exp);
        repeat (LAT - 1) step();
        check({name, "_valid"}, 32'(rd_valid), 32'd1);
        check({name, "_data"}, 32'(rd_data), 32'(exp));
        step();
        check({name, "_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic read(input string name, input int ch, input int a, input logic [DW-1:0] exp);
        rd = 1'b1; rd_ch = CW'(ch); rd_addr = AW'(a);
        step();
        rd = 1'b0;
        finish_read(name, exp);
    endtask

    task automatic burst_read(input int base, input int cnt, output int total, output int maxrun);
        int run;
        run = 0; total = 0; maxrun = 0;
        for (int i = 0; i < cnt + LAT; i++) begin
            if (i < cnt) begin
                rd = 1'b1; rd_ch = CW'((base + i) >> AW); rd_addr = AW'(base + i);
            end else begin
                rd = 1'b0;
            end
            step();
            if (rd_valid) begin
                total++; run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        rd = 1'b0;
    endtask

    initial begin
        int n;
        int total;
        int maxrun;
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        model_reset();

        // Reset state, with rd held high throughout the first sweep
        rd = 1'b1;
        repeat (3) step();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        wait_ready(n);
        rd = 1'b0;
        check("sweep_after_reset", 32'(n), 32'd16);

        // Write then read back; untouched word reads as cleared
        write(1, 5, 16'hBEEF);
        read("rd_c1a5", 1, 5, 16'hBEEF);
        read("rd_c0a5", 0, 5, 16'h0000);

        // Same-word collision returns the new data; different words independent
        wr = 1'b1; wr_ch = 1'b0; wr_addr = 3'd2; wr_data = 16'h1234;
        rd = 1'b1; rd_ch = 1'b0; rd_addr = 3'd2;
        step();
        wr = 1'b0; rd = 1'b0;
        finish_read("bypass_c0a2", 16'h1234);
        wr = 1'b1; wr_ch = 1'b0; wr_addr = 3'd3; wr_data = 16'h5555;
        rd = 1'b1; rd_ch = 1'b1; rd_addr = 3'd5;
        step();
        wr = 1'b0; rd = 1'b0;
        finish_read("nocoll_c1a5", 16'hBEEF);
        read("rd_c0a3", 0, 3, 16'h5555);

        // Back-to-back reads of ch0 a0..a7
        for (int i = 0; i < 8; i++) write(0, i, DW'(16'h0100 + i));
        burst_read(0, 8, total, maxrun);
        check("b2b8_total", 32'(total), 32'd8);
        check("b2b8_run", 32'(maxrun), 32'd8);

        // Fill with index, read all, clear, confirm everything is zero
        for (int i = 0; i < WORDS; i++) write(i >> AW, i % 8, DW'(i));
        burst_read(0, WORDS, total, maxrun);
        check("b2b16_run", 32'(maxrun), 32'd16);
        read("fill_w9", 1, 1, 16'h0009);
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr = 1'b1; wr_ch = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777;
        rd = 1'b1; rd_ch = 1'b1; rd_addr = 3'd1;
        wait_ready(n);
        wr = 1'b0; rd = 1'b0;
        check("clr_low_cycles", 32'(n), 32'd16);
        for (int i = 0; i < WORDS; i++) read("after_clr", i >> AW, i % 8, 16'h0000);

        // Reset during an in-flight read
        write(0, 4, 16'hABCD);
        rd = 1'b1; rd_ch = 1'b0; rd_addr = 3'd4;
        step();
        rd = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_rd_ready", 32'(ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        wait_ready(n);
        check("sweep_after_rst1", 32'(n), 32'd16);

        // Reset at cycle 7 of a sweep, with wr/rd requested while not ready
        write(0, 6, 16'h9999);
        read("rd_c0a6", 0, 6, 16'h9999);
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr = 1'b1; wr_ch = 1'b0; wr_addr = 3'd6; wr_data = 16'h4321;
        rd = 1'b1; rd_ch = 1'b0; rd_addr = 3'd6;
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_sweep_ready", 32'(ready), 32'd0);
        check("rst_sweep_valid", 32'(rd_valid), 32'd0);
        check("rst_sweep_data", 32'(rd_data), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        wait_ready(n);
        wr = 1'b0; rd = 1'b0;
        check("sweep_after_rst2", 32'(n), 32'd16);
        read("ignored_c0a6", 0, 6, 16'h0000);
        read("ignored_c0a4", 0, 4, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
